d_stream_sampler: RTL
=====================

// Module: d_stream_sampler
// PURPOSE
//  Receive-side end of the single-bit D stream: takes a serial bit held for BIT_CYCLES
//  clocks per bit, synchronises it, samples each bit at mid-period and assembles WIDTH
//  bits into a parallel word with a one-cycle valid strobe.
//  Sits after any D-flip-flop source/stimulus stage and presents words to downstream logic.
// PARAMETERS
//  WIDTH        15  bits per captured word (>=2)
//  BIT_CYCLES    5  clocks each serial bit is held (>=3)
//  SYNC_STAGES   2  flip-flops in the d input synchroniser (>=2)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  d           in   1      serial data, asynchronous to clk
//  start       in   1      one-cycle pulse: first bit begins at this edge (as seen at d_sync)
//  q           out  1      last sampled bit
//  qbar        out  1      always ~q
//  busy        out  1      high while capturing
//  data        out  WIDTH  assembled word, first bit received in MSB
//  word_valid  out  1      one-cycle strobe, data valid and stable
// BEHAVIOUR
//  Clock is clk; reset is rst_n, asynchronous assert, active-low, synchronous deassert by
//  system. Reset values: q=0, qbar=1, busy=0, data=0, word_valid=0, state=IDLE, counters=0,
//  all synchroniser flops=0.
//  d passes through SYNC_STAGES flops -> d_sync; all sampling uses d_sync only.
//  FSM: IDLE -> CAPTURE on start; CAPTURE -> DONE after WIDTH*BIT_CYCLES cycles;
//  DONE -> IDLE unconditionally after one cycle.
//  CAPTURE: cyc_cnt 0..BIT_CYCLES-1 wraps, bit_cnt increments on wrap.
//  Sample when cyc_cnt == BIT_CYCLES/2 (integer): shift = {shift[WIDTH-2:0], d_sync}; q <= d_sync.
//  DONE: data <= shift register (full WIDTH), word_valid=1 for exactly this cycle.
//  data holds its value until the next DONE; never changes while word_valid=0.
//  Latency: start sampled at edge E0 -> word_valid high after edge E0+WIDTH*BIT_CYCLES+1.
//  busy=1 exactly in CAPTURE.
//  start during CAPTURE or DONE: ignored, no restart, no error.
//  start and rst_n low together: reset wins.
//  rst_n low mid-capture: immediate abort to IDLE, partial word discarded, no word_valid.
//  Counters sized $clog2(BIT_CYCLES) / $clog2(WIDTH+1); no wrap beyond terminal values.
// STRUCTURE
//  Shared package: state enum {IDLE, CAPTURE, DONE} and the default WIDTH/BIT_CYCLES constants.
//  One sub-module: bit_sync (SYNC_STAGES-deep flip-flop chain, async active-low clear).
//  FSM, counters and shift register stay in the top level.
// TESTING
//  clk period 20 ns; bench drives d, asserts start SYNC_STAGES cycles after the first bit edge.
//  1 Reset: rst_n=0 -> q=0, qbar=1, busy=0, data=0, word_valid=0; hold 3 cycles, no change.
//  2 Word: defaults, d held 100 ns/bit = 0,1,0,1,0,0,1,0,0,0,1,1,1,1,0 ->
//    data=15'h291E, one word_valid pulse 76 edges after start, busy low again after it.
//  3 All ones then all zeros words back-to-back -> data=15'h7FFF then 15'h0000,
//    q follows the last bit, qbar==~q on every cycle.
//  4 Second start pulse 10 cycles into capture -> ignored; word and timing identical to scenario 2.
//  5 rst_n low for 1 cycle at bit 7 -> busy=0 at once, no word_valid, data stays 0;
//    a fresh start then captures 15'h291E correctly.
//  6 d glitch of 1 clock at cyc_cnt=0 of a 0-bit -> sampled bit still 0, data unaffected.

Source files
------------

// File: rtl/d_stream_sampler_pkg.sv
// Shared types and default sizing for the D stream sampler.
// Holds the capture FSM state enum and default parameter values.
package d_stream_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    localparam int DEF_WIDTH       = 15;
    localparam int DEF_BIT_CYCLES  = 5;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/d_stream_sampler_bit_sync.sv
// bit_sync: STAGES-deep flop chain bringing async d into clk domain.
// Ports: clk, rst_n (async clear), d (async in), d_sync (synchronised out).
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic d_sync
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign d_sync = chain[STAGES-1];

endmodule

// File: rtl/d_stream_sampler.sv
// d_stream_sampler: mid-bit sampling of a serial bit stream into words.
// Ports: clk, rst_n, d, start in; q, qbar, busy, data, word_valid out.
module d_stream_sampler
    import d_stream_sampler_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic             start,
    output logic             q,
    output logic             qbar,
    output logic             busy,
    output logic [WIDTH-1:0] data,
    output logic             word_valid
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_MID  = CW'(BIT_CYCLES / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic             d_sync;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;
    logic             wrap;
    logic             last;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d),
        .d_sync (d_sync)
    );

    assign wrap = (cyc_cnt == CYC_LAST);
    assign last = wrap && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CAPTURE;
            CAPTURE: if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counters idle at zero outside CAPTURE; bit_cnt holds at
    // its terminal value rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else if (state != CAPTURE) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else if (wrap) begin
            cyc_cnt <= '0;
            if (bit_cnt != BIT_LAST) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    // Sampling mid-bit keeps clear of edge jitter and short glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            q     <= 1'b0;
        end else if (state == CAPTURE && cyc_cnt == CYC_MID) begin
            shift <= {shift[WIDTH-2:0], d_sync};
            q     <= d_sync;
        end
    end

    // data only updates on the DONE edge, so it is stable whenever
    // word_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= (state == DONE);
            if (state == DONE) begin
                data <= shift;
            end
        end
    end

    assign busy = (state == CAPTURE);
    assign qbar = ~q;

endmodule
